// File: rtl/uart_rx_if.sv
// Valid/ready word channel between the UART receiver and its consumer.
//   rx_data  : received word, stable while rx_valid is high
//   rx_valid : rx_data holds an unconsumed word
//   rx_ready : consumer takes the word when rx_valid && rx_ready
// master = receiver (produces words), slave = consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: recovers start + DATA_BITS (LSB first) + one stop bit frames
// from the asynchronous line rxd at CLKS_PER_BIT clocks per bit, and hands each
// good word to the consumer over a valid/ready channel.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   rxd         : serial line, idle high, asynchronous to clk
//   bus         : word channel (rx_data / rx_valid out, rx_ready in)
//   busy        : receiver is somewhere other than IDLE
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun_err : one-cycle pulse, good word dropped because rx_valid was held
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  uart_rx_if.master bus,
  output logic      busy,
  output logic      frame_err,
  output logic      overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        bcnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sreg;

  logic tick_half, tick_bit;
  logic stop_ok, stop_bad;
  logic accept;

  assign tick_half = (bcnt == HALF_LAST);
  assign tick_bit  = (bcnt == BIT_LAST);
  assign accept    = bus.rx_valid && bus.rx_ready;

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // see pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next defaults to state before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (!rxs) state_next = S_START;
      // A start bit that is high again at its midpoint was a glitch.
      S_START: if (tick_half) state_next = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (tick_bit && idx == IDX_LAST) state_next = S_STOP;
      S_STOP:  if (tick_bit) state_next = rxs ? S_IDLE : S_WAIT;
      // A line held low (break) must return high before a new start counts.
      S_WAIT:  if (rxs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output / strobe decode.
  always_comb begin
    busy     = (state != S_IDLE);
    stop_ok  = (state == S_STOP) && tick_bit && rxs;
    stop_bad = (state == S_STOP) && tick_bit && !rxs;
  end

  // Synchronizer, bit timing, shift register and the output word register.
  // NOTE: the synchronizer resets to 1 (idle line) so leaving reset can never
  // look like a falling edge; every other register, shift register included,
  // resets to 0 so no partial frame survives a mid-frame reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rxs          <= 1'b1;
      bcnt         <= '0;
      idx          <= '0;
      sreg         <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;

      frame_err   <= stop_bad;
      overrun_err <= stop_ok && bus.rx_valid && !bus.rx_ready;

      unique case (state)
        S_START: begin
          bcnt <= tick_half ? '0 : bcnt + 1'b1;
          idx  <= '0;
        end
        S_DATA: begin
          if (tick_bit) begin
            bcnt <= '0;
            idx  <= idx + 1'b1;
            // Shift right so the first (LSB) bit lands in bit 0 after the last.
            sreg <= {rxs, sreg[DATA_BITS-1:1]};
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        S_STOP:  bcnt <= tick_bit ? '0 : bcnt + 1'b1;
        default: bcnt <= '0;
      endcase

      // A word consumed in this same cycle frees the slot for the new one.
      if (stop_ok && (!bus.rx_valid || bus.rx_ready)) begin
        bus.rx_data  <= sreg;
        bus.rx_valid <= 1'b1;
      end else if (accept) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8).
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic busy, frame_err, overrun_err;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .bus         (bus),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: words the consumer should see, error events
  // expected, and whether an unconsumed word is being held.
  logic [DB-1:0] exp_q[$];
  int            exp_ferr = 0;
  int            exp_oerr = 0;
  bit            pending  = 1'b0;

  // Observed error pulses (counted in cycles, so a stretched pulse shows up).
  int n_ferr = 0;
  int n_oerr = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: a good frame is delivered unless a word is still held
  // with the consumer stalled, in which case it is dropped as an overrun.
  task automatic model_frame(input logic [DB-1:0] d, input logic stop);
    if (!stop) exp_ferr++;
    else if (!pending || bus.rx_ready) begin
      exp_q.push_back(d);
      pending = !bus.rx_ready;
    end else exp_oerr++;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    model_frame(d, stop);
    rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      cyc(CPB);
    end
    rxd = stop;
    cyc(CPB);
  endtask

  // Monitor: pops the scoreboard on every handshake and tallies error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)   n_ferr++;
      if (overrun_err) n_oerr++;
      if ((frame_err || overrun_err) && bus.rx_valid && !prev_valid) begin
        n_vec++;
        n_miss++;
        $display("FAIL err_with_valid_rise: error pulse on rx_valid rise (t=%0t)", $time);
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_word: got 0x%0h, want no word (t=%0t)", bus.rx_data, $time);
        end else begin
          check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_valid = bus.rx_valid;
  end

  initial begin
    int k;
    logic [DB-1:0] d;

    bus.rx_ready = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    check("rst_valid", 32'(bus.rx_valid), 0);
    check("rst_data", 32'(bus.rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_oerr", 32'(overrun_err), 0);
    rst_n = 1'b1;
    cyc(5);

    // Single good frame.
    bus.rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    cyc(CPB);
    check("a5_drained", exp_q.size(), 0);
    check("a5_ferr", n_ferr, exp_ferr);
    check("a5_oerr", n_oerr, exp_oerr);

    // Short low glitch on the line.
    rxd = 1'b0;
    cyc(4);
    check("glitch_busy_hi", 32'(busy), 1);
    rxd = 1'b1;
    cyc(20);
    check("glitch_busy_lo", 32'(busy), 0);
    check("glitch_valid", 32'(bus.rx_valid), 0);
    check("glitch_ferr", n_ferr, exp_ferr);

    // Framing error, line then held low.
    send_frame(8'h3C, 1'b0);
    cyc(3 * CPB);
    check("ferr_count", n_ferr, exp_ferr);
    check("ferr_wait_busy", 32'(busy), 1);
    check("ferr_valid", 32'(bus.rx_valid), 0);
    rxd = 1'b1;
    cyc(5);
    check("ferr_idle", 32'(busy), 0);

    // Overrun: two back-to-back frames with the consumer stalled.
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rxd = 1'b1;
    cyc(CPB);
    check("ovr_valid", 32'(bus.rx_valid), 1);
    check("ovr_data", 32'(bus.rx_data), 32'h11);
    check("ovr_count", n_oerr, exp_oerr);
    bus.rx_ready = 1'b1;
    pending = 1'b0;
    cyc(2);
    check("ovr_cleared", 32'(bus.rx_valid), 0);
    check("ovr_drained", exp_q.size(), 0);

    // Reset in the middle of data bit 4; the frame must vanish.
    d = 8'hC3;
    rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      cyc(CPB);
    end
    rxd = d[4];
    cyc(CPB / 2);
    rst_n = 1'b0;
    rxd = 1'b1;
    cyc(1);
    check("mid_rst_valid", 32'(bus.rx_valid), 0);
    check("mid_rst_data", 32'(bus.rx_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ferr", 32'(frame_err), 0);
    check("mid_rst_oerr", 32'(overrun_err), 0);
    rst_n = 1'b1;
    cyc(2 * CPB);
    check("post_rst_busy", 32'(busy), 0);
    send_frame(8'h5A, 1'b1);
    rxd = 1'b1;
    cyc(CPB);
    check("5a_drained", exp_q.size(), 0);

    // Random frames, zero idle gap.
    for (int i = 0; i < 256; i++) send_frame(8'($urandom), 1'b1);
    rxd = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      cyc(1);
      k++;
    end
    check("rand_drained", exp_q.size(), 0);
    check("final_ferr", n_ferr, exp_ferr);
    check("final_oerr", n_oerr, exp_oerr);
    check("final_valid", 32'(bus.rx_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
